sr_retire_monitor: RTL and testbench

Synthesizable retirement monitor for the schoolRISCV core with instruction cache.
- Observes the fetch-ready strobe, PC and instruction word each cycle.
- Counts retired instructions, total cycles and cache-stall cycles.
- Detects a programmable halt instruction and a no-progress timeout.
- Keeps a circular history of the last DEPTH retired (pc, instr) pairs, readable by index.
- Sits beside sr_cpu in sm_top. It replaces testbench-only $write/$stop monitoring with hardware that both the bench and FPGA debug logic can read.

---
 rtl/sr_mon_pkg.sv | 19 +
 rtl/sr_mon_history.sv | 67 ++++++
 rtl/sr_retire_monitor.sv | 139 +++++++++++++
 tb/tb_sr_retire_monitor.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_mon_pkg.sv
// Shared definitions for the schoolRISCV retirement monitor: state encoding
// and the default halt instruction (beq x0,x0,0 -- the classic "spin here").
package sr_mon_pkg;

    typedef enum logic [1:0] {
        MON_IDLE    = 2'b00,
        MON_RUN     = 2'b01,
        MON_HALTED  = 2'b10,
        MON_TIMEOUT = 2'b11
    } monState_e;

    localparam logic [31:0] HALT_INSTR_DEF = 32'h0000_0063;

    // Terminal states freeze the monitor until the next rst/clr.
    function automatic logic isTerminal(monState_e s);
        return (s == MON_HALTED) || (s == MON_TIMEOUT);
    endfunction

endpackage

// File: rtl/sr_mon_history.sv
// Circular history of the last DEPTH retired (pc, instr) pairs.
// Index 0 on the read side is always the newest entry; reads are combinational
// and see the contents as of the start of the cycle (a write lands next cycle).
module sr_mon_history
    import sr_mon_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PC_W-1:0]  wrPc,
    input  logic [31:0]      wrInstr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PC_W-1:0]  rd_pc,
    output logic [31:0]      rd_instr,
    output logic [IDX_W:0]   hist_cnt
);

    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    logic [PC_W-1:0]  pcMem    [DEPTH];
    logic [31:0]      instrMem [DEPTH];
    logic [IDX_W-1:0] wPtr;
    logic [IDX_W:0]   validCnt;
    logic [IDX_W-1:0] rdSlot;
    logic             rdValid;

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (we) begin
            pcMem[wPtr]    <= wrPc;
            instrMem[wPtr] <= wrInstr;
        end
    end

    // Write pointer wraps naturally (DEPTH is a power of two); count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            wPtr     <= '0;
            validCnt <= '0;
        end else if (we) begin
            wPtr <= wPtr + ONE_IDX;
            if (validCnt != FULL_CNT) begin
                validCnt <= validCnt + (IDX_W + 1)'(1);
            end
        end
    end

    // Newest-relative lookup; unwritten slots read as zero.
    always_comb begin
        rdSlot   = wPtr - ONE_IDX - rd_idx;
        rdValid  = ({1'b0, rd_idx} < validCnt);
        rd_pc    = '0;
        rd_instr = '0;
        if (rdValid) begin
            rd_pc    = pcMem[rdSlot];
            rd_instr = instrMem[rdSlot];
        end
    end

    assign hist_cnt = validCnt;

endmodule

// File: rtl/sr_retire_monitor.sv
// Retirement monitor for schoolRISCV with instruction cache. Watches the
// fetch-ready strobe beside sr_cpu, counts retires/cycles/stalls, detects the
// halt instruction or a no-progress timeout, and keeps a readable history.
//
// state       | meaning
// ------------+------------------------------------------------------------
// MON_IDLE    | one dead cycle after rst/clr, nothing counted
// MON_RUN     | counting; history written on every retire
// MON_HALTED  | halt instruction retired; everything frozen
// MON_TIMEOUT | TIMEOUT consecutive stall cycles seen; everything frozen
module sr_retire_monitor
    import sr_mon_pkg::*;
#(
    parameter int          PC_W       = 32,
    parameter int          CNT_W      = 32,
    parameter int          DEPTH      = 8,
    parameter int          TIMEOUT    = 1024,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF,
    localparam int         IDX_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             im_drdy,
    input  logic [PC_W-1:0]  pc,
    input  logic [31:0]      instr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PC_W-1:0]  rd_pc,
    output logic [31:0]      rd_instr,
    output logic [IDX_W:0]   hist_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] max_stall,
    output logic [1:0]       state,
    output logic             done
);

    // The no-progress timer is a down-counter reloaded on every retire; it
    // fires on the stall cycle that finds it already at zero, which is the
    // TIMEOUT-th consecutive stall.
    localparam int             TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    monState_e        st;
    logic             doneR;
    logic [CNT_W-1:0] retireCnt;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] maxStall;
    logic [CNT_W-1:0] curStall;
    logic [CNT_W-1:0] curStallNext;
    logic [TO_W-1:0]  toCnt;
    logic             clear;
    logic             retire;
    logic             isHalt;

    assign clear        = rst | clr;
    assign retire       = (st == MON_RUN) && im_drdy && !clear;
    assign isHalt       = (instr == HALT_INSTR);
    assign curStallNext = curStall + CNT_ONE;

    // Sequencer plus all counters: one registered process so every output
    // changes on the same edge as the state it describes.
    always_ff @(posedge clk) begin
        if (clear) begin
            st        <= MON_IDLE;
            doneR     <= 1'b0;
            retireCnt <= '0;
            cycleCnt  <= '0;
            stallCnt  <= '0;
            maxStall  <= '0;
            curStall  <= '0;
            toCnt     <= TO_LOAD;
        end else begin
            case (st)
                MON_IDLE: begin
                    st <= MON_RUN;
                end
                MON_RUN: begin
                    cycleCnt <= cycleCnt + CNT_ONE;
                    if (im_drdy) begin
                        // A retire always beats a pending timeout.
                        retireCnt <= retireCnt + CNT_ONE;
                        curStall  <= '0;
                        toCnt     <= TO_LOAD;
                        if (isHalt) begin
                            st    <= MON_HALTED;
                            doneR <= 1'b1;
                        end
                    end else begin
                        stallCnt <= stallCnt + CNT_ONE;
                        curStall <= curStallNext;
                        if (curStallNext > maxStall) begin
                            maxStall <= curStallNext;
                        end
                        if (toCnt == '0) begin
                            st    <= MON_TIMEOUT;
                            doneR <= 1'b1;
                        end else begin
                            toCnt <= toCnt - TO_W'(1);
                        end
                    end
                end
                MON_HALTED, MON_TIMEOUT: begin
                    st    <= st;
                    doneR <= isTerminal(st);
                end
                default: begin
                    st <= MON_IDLE;
                end
            endcase
        end
    end

    sr_mon_history #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_history (
        .clk      (clk),
        .rst      (clear),
        .we       (retire),
        .wrPc     (pc),
        .wrInstr  (instr),
        .rd_idx   (rd_idx),
        .rd_pc    (rd_pc),
        .rd_instr (rd_instr),
        .hist_cnt (hist_cnt)
    );

    assign retire_cnt = retireCnt;
    assign cycle_cnt  = cycleCnt;
    assign stall_cnt  = stallCnt;
    assign max_stall  = maxStall;
    assign state      = st;
    assign done       = doneR;

endmodule

// File: tb/tb_sr_retire_monitor.sv
// Bench for sr_retire_monitor: directed vector table, hand sequences for the
// halt/timeout/clear corners, then random traffic against a log-based model.
// Two instances share the inputs: A with TIMEOUT=1024, B with TIMEOUT=4.
module tb_sr_retire_monitor;
    import sr_mon_pkg::*;

    localparam int          LOG  = 4096;
    localparam logic [31:0] HALT = 32'h0000_0063;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        im_drdy = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [2:0]  rd_idx = '0;

    logic [31:0] rdPcA, rdInA, retA, cycA, stlA, maxA;
    logic [31:0] rdPcB, rdInB, retB, cycB, stlB, maxB;
    logic [3:0]  histA, histB;
    logic [1:0]  stA, stB;
    logic        doneA, doneB;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    sr_retire_monitor #(.TIMEOUT(1024)) dutA (
        .clk(clk), .rst(rst), .clr(clr), .im_drdy(im_drdy), .pc(pc), .instr(instr),
        .rd_idx(rd_idx), .rd_pc(rdPcA), .rd_instr(rdInA), .hist_cnt(histA),
        .retire_cnt(retA), .cycle_cnt(cycA), .stall_cnt(stlA), .max_stall(maxA),
        .state(stA), .done(doneA)
    );

    sr_retire_monitor #(.TIMEOUT(4)) dutB (
        .clk(clk), .rst(rst), .clr(clr), .im_drdy(im_drdy), .pc(pc), .instr(instr),
        .rd_idx(rd_idx), .rd_pc(rdPcB), .rd_instr(rdInB), .hist_cnt(histB),
        .retire_cnt(retB), .cycle_cnt(cycB), .stall_cnt(stlB), .max_stall(maxB),
        .state(stB), .done(doneB)
    );

    // ---------------- reference model: full retire log per instance ----------
    int          mTo [2] = '{1024, 4};
    int          mSt [2];       // 0 idle, 1 run, 2 halted, 3 timeout
    int          mLen[2];
    logic [31:0] mRet[2], mCyc[2], mStall[2], mMax[2], mCur[2];
    logic [31:0] logPc[2][LOG];
    logic [31:0] logIn[2][LOG];

    task automatic modelStep(input int m);
        if (rst || clr) begin
            mSt[m] = 0; mLen[m] = 0;
            mRet[m] = 0; mCyc[m] = 0; mStall[m] = 0; mMax[m] = 0; mCur[m] = 0;
        end else if (mSt[m] == 0) begin
            mSt[m] = 1;
        end else if (mSt[m] == 1) begin
            mCyc[m] = mCyc[m] + 1;
            if (im_drdy) begin
                mRet[m] = mRet[m] + 1;
                logPc[m][mLen[m] % LOG] = pc;
                logIn[m][mLen[m] % LOG] = instr;
                mLen[m] = mLen[m] + 1;
                mCur[m] = 0;
                if (instr == HALT) mSt[m] = 2;
            end else begin
                mStall[m] = mStall[m] + 1;
                mCur[m] = mCur[m] + 1;
                if (mCur[m] > mMax[m]) mMax[m] = mCur[m];
                if (mCur[m] == 32'(mTo[m])) mSt[m] = 3;
            end
        end
    endtask

    function automatic int modelHist(input int m);
        return (mLen[m] > 8) ? 8 : mLen[m];
    endfunction

    task automatic modelRead(input int m, input int idx, output logic [31:0] ePc, output logic [31:0] eIn);
        ePc = '0;
        eIn = '0;
        if (idx < modelHist(m)) begin
            ePc = logPc[m][(mLen[m] - 1 - idx) % LOG];
            eIn = logIn[m][(mLen[m] - 1 - idx) % LOG];
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkModel(input int m);
        logic [31:0] ePc, eIn;
        string t;
        t = (m == 0) ? "A" : "B";
        modelRead(m, int'(rd_idx), ePc, eIn);
        if (m == 0) begin
            chk({t, ".retire"}, retA, mRet[0]);
            chk({t, ".cycle"},  cycA, mCyc[0]);
            chk({t, ".stall"},  stlA, mStall[0]);
            chk({t, ".max"},    maxA, mMax[0]);
            chk({t, ".state"},  32'(stA), 32'(mSt[0]));
            chk({t, ".done"},   32'(doneA), 32'(mSt[0] >= 2));
            chk({t, ".hist"},   32'(histA), 32'(modelHist(0)));
            chk({t, ".rdPc"},   rdPcA, ePc);
            chk({t, ".rdIn"},   rdInA, eIn);
        end else begin
            chk({t, ".retire"}, retB, mRet[1]);
            chk({t, ".cycle"},  cycB, mCyc[1]);
            chk({t, ".stall"},  stlB, mStall[1]);
            chk({t, ".max"},    maxB, mMax[1]);
            chk({t, ".state"},  32'(stB), 32'(mSt[1]));
            chk({t, ".done"},   32'(doneB), 32'(mSt[1] >= 2));
            chk({t, ".hist"},   32'(histB), 32'(modelHist(1)));
            chk({t, ".rdPc"},   rdPcB, ePc);
            chk({t, ".rdIn"},   rdInB, eIn);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        checkModel(0);
        checkModel(1);
    endtask

    // ---------------- directed vector table (instance A) ----------------
    typedef struct {
        logic        drdy;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [2:0]  idx;
        logic [31:0] eRet, eCyc, eStall, eMax;
        logic [3:0]  eHist;
        logic [31:0] eRd;
        logic [1:0]  eSt;
        logic        eDone;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(input logic d, input logic [31:0] p, input logic [31:0] i,
                                input logic [2:0] x, input logic [31:0] r, input logic [31:0] c,
                                input logic [31:0] s, input logic [31:0] mx, input logic [3:0] h,
                                input logic [31:0] rd, input logic [1:0] st, input logic dn);
        vec_t v;
        v.drdy = d; v.pc = p; v.ins = i; v.idx = x;
        v.eRet = r; v.eCyc = c; v.eStall = s; v.eMax = mx;
        v.eHist = h; v.eRd = rd; v.eSt = st; v.eDone = dn;
        return v;
    endfunction

    initial begin
        logic [31:0] prevPc;
        int r;

        //             drdy pc            instr idx ret cyc stl max hist rd     state        done
        vt[0]  = mk(1, 32'hDEAD0000, NOP,  0,  0,  0,  0,  0,  0, 32'h0,  MON_RUN,     0);
        vt[1]  = mk(1, 32'h0,        NOP,  0,  1,  1,  0,  0,  1, 32'h0,  MON_RUN,     0);
        vt[2]  = mk(1, 32'h4,        NOP,  1,  2,  2,  0,  0,  2, 32'h0,  MON_RUN,     0);
        vt[3]  = mk(1, 32'h8,        NOP,  0,  3,  3,  0,  0,  3, 32'h8,  MON_RUN,     0);
        vt[4]  = mk(1, 32'hC,        NOP,  1,  4,  4,  0,  0,  4, 32'h8,  MON_RUN,     0);
        vt[5]  = mk(1, 32'h10,       NOP,  0,  5,  5,  0,  0,  5, 32'h10, MON_RUN,     0);
        vt[6]  = mk(0, 32'hBAD,      NOP,  4,  5,  6,  1,  1,  5, 32'h0,  MON_RUN,     0);
        vt[7]  = mk(1, 32'h14,       NOP,  5,  6,  7,  1,  1,  6, 32'h0,  MON_RUN,     0);
        vt[8]  = mk(0, 32'hBAD,      NOP,  6,  6,  8,  2,  1,  6, 32'h0,  MON_RUN,     0);
        vt[9]  = mk(0, 32'hBAD,      NOP,  0,  6,  9,  3,  2,  6, 32'h14, MON_RUN,     0);
        vt[10] = mk(0, 32'hBAD,      NOP,  1,  6, 10,  4,  3,  6, 32'h10, MON_RUN,     0);
        vt[11] = mk(1, 32'h18,       NOP,  0,  7, 11,  4,  3,  7, 32'h18, MON_RUN,     0);
        vt[12] = mk(0, 32'hBAD,      NOP,  7,  7, 12,  5,  3,  7, 32'h0,  MON_RUN,     0);
        vt[13] = mk(0, 32'hBAD,      NOP,  6,  7, 13,  6,  3,  7, 32'h0,  MON_RUN,     0);
        vt[14] = mk(1, 32'h1C,       NOP,  2,  8, 14,  6,  3,  8, 32'h14, MON_RUN,     0);
        vt[15] = mk(1, 32'h20,       NOP,  0,  9, 15,  6,  3,  8, 32'h20, MON_RUN,     0);
        vt[16] = mk(1, 32'h24,       NOP,  0, 10, 16,  6,  3,  8, 32'h24, MON_RUN,     0);
        vt[17] = mk(1, 32'h28,       NOP,  7, 11, 17,  6,  3,  8, 32'hC,  MON_RUN,     0);
        vt[18] = mk(1, 32'h20,       HALT, 0, 12, 18,  6,  3,  8, 32'h20, MON_HALTED,  1);
        vt[19] = mk(1, 32'h44,       NOP,  0, 12, 18,  6,  3,  8, 32'h20, MON_HALTED,  1);
        vt[20] = mk(0, 32'h48,       NOP,  1, 12, 18,  6,  3,  8, 32'h28, MON_HALTED,  1);

        // Reset state
        rst = 1'b1;
        tick();
        chk("reset.state", 32'(stA), 32'(MON_IDLE));
        chk("reset.done", 32'(doneA), 32'h0);
        chk("reset.retire", retA, 32'h0);
        chk("reset.hist", 32'(histA), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            im_drdy = vt[i].drdy;
            pc      = vt[i].pc;
            instr   = vt[i].ins;
            rd_idx  = vt[i].idx;
            tick();
            chk($sformatf("vec%0d.retire", i), retA, vt[i].eRet);
            chk($sformatf("vec%0d.cycle", i), cycA, vt[i].eCyc);
            chk($sformatf("vec%0d.stall", i), stlA, vt[i].eStall);
            chk($sformatf("vec%0d.max", i), maxA, vt[i].eMax);
            chk($sformatf("vec%0d.hist", i), 32'(histA), 32'(vt[i].eHist));
            chk($sformatf("vec%0d.rdPc", i), rdPcA, vt[i].eRd);
            chk($sformatf("vec%0d.state", i), 32'(stA), 32'(vt[i].eSt));
            chk($sformatf("vec%0d.done", i), 32'(doneA), 32'(vt[i].eDone));
        end

        // clr while HALTED: back to IDLE with everything zeroed, then RUN
        clr = 1'b1; im_drdy = 1'b0; rd_idx = 3'd0;
        tick();
        chk("clr.state", 32'(stA), 32'(MON_IDLE));
        chk("clr.done", 32'(doneA), 32'h0);
        chk("clr.retire", retA, 32'h0);
        chk("clr.cycle", cycA, 32'h0);
        chk("clr.stall", stlA, 32'h0);
        chk("clr.max", maxA, 32'h0);
        chk("clr.hist", 32'(histA), 32'h0);
        chk("clr.rdPc", rdPcA, 32'h0);
        clr = 1'b0;
        tick();
        chk("clr.run", 32'(stA), 32'(MON_RUN));

        // Same-cycle write/read returns the pre-write newest entry
        im_drdy = 1'b1; pc = 32'h400; instr = NOP;
        tick();
        prevPc = 32'h400;
        pc = 32'h500;
        #1;
        chk("prewrite.rdPc", rdPcA, prevPc);
        tick();
        chk("postwrite.rdPc", rdPcA, 32'h500);

        // rst mid-RUN with a retire pending: nothing counted
        rst = 1'b1; im_drdy = 1'b1; pc = 32'h600;
        tick();
        chk("rstRun.retire", retA, 32'h0);
        chk("rstRun.state", 32'(stA), 32'(MON_IDLE));
        rst = 1'b0; im_drdy = 1'b0;
        tick();

        // Instance B: timeout after exactly 4 stalls
        for (int i = 0; i < 3; i++) tick();
        chk("to3.state", 32'(stB), 32'(MON_RUN));
        tick();
        chk("to4.state", 32'(stB), 32'(MON_TIMEOUT));
        chk("to4.stall", stlB, 32'h4);
        chk("to4.done", 32'(doneB), 32'h1);
        chk("to4.stateA", 32'(stA), 32'(MON_RUN));
        im_drdy = 1'b1; pc = 32'h700;
        tick();
        chk("toFrozen.retire", retB, 32'h0);
        chk("toFrozen.state", 32'(stB), 32'(MON_TIMEOUT));

        // Retire on the 4th stall-candidate cycle wins over timeout
        rst = 1'b1; im_drdy = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) tick();
        im_drdy = 1'b1; pc = 32'h800;
        tick();
        chk("noTo.state", 32'(stB), 32'(MON_RUN));
        im_drdy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("noTo3.state", 32'(stB), 32'(MON_RUN));
        chk("noTo3.max", maxB, 32'h3);
        tick();
        chk("noTo4.state", 32'(stB), 32'(MON_TIMEOUT));
        chk("noTo4.stall", stlB, 32'h7);

        // Random traffic against the model (checked inside tick)
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 149));
            rst     = (r == 0);
            clr     = (r == 1);
            im_drdy = ($urandom_range(0, 9) < 6);
            pc      = $urandom & 32'hFFFF_FFFC;
            instr   = ($urandom_range(0, 79) == 0) ? HALT : $urandom;
            rd_idx  = 3'($urandom_range(0, 7));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
